// File: rtl/cpu7_mem_arbiter_if.sv
// cpu7_mem_arbiter_if: core-side request bus and shared-memory port of the cpu7 memory arbiter
interface cpu7_mem_arbiter_if #(
    parameter int CORES  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [CORES-1:0]        req;
    logic [CORES-1:0]        we;
    logic [CORES*ADDR_W-1:0] addr;
    logic [CORES*DATA_W-1:0] wdata;
    logic [CORES-1:0]        lock;
    logic [CORES-1:0]        ack;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic [$clog2(CORES)-1:0] grant_id;
    logic                    busy;

    modport slave (
        input  req, we, addr, wdata, lock, mem_rdata,
        output ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, grant_id, busy
    );

    modport master (
        output req, we, addr, wdata, lock, mem_rdata,
        input  ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, grant_id, busy
    );
endinterface

// File: rtl/cpu7_mem_arbiter.sv
// cpu7_mem_arbiter: round-robin arbiter serialising core accesses onto one memory port (optional bus lock via CPU7_ARB_LOCK_EN)
module cpu7_mem_arbiter #(
    parameter int CORES   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    cpu7_mem_arbiter_if.slave bus
);
    localparam int GW = $clog2(CORES);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t           state, state_n;
    logic [GW-1:0]    last_grant, win;
    logic [CW-1:0]    cnt;
    logic             found, holds, lock_n;
    logic [CORES-1:0] elig, gsel;

    assign gsel = CORES'(1) << bus.grant_id;
    assign elig = holds ? (bus.req & gsel) : bus.req;

`ifdef CPU7_ARB_LOCK_EN
    logic lock_v;
    assign holds  = lock_v & bus.lock[bus.grant_id];
    assign lock_n = state == ACK ? bus.lock[bus.grant_id] : state == IDLE ? holds : lock_v;
    // lock holder flag; the holder's index is grant_id since the pointer stops on it
    always_ff @(posedge clk)
        lock_v <= rst_n ? lock_n : 1'b0;
`else
    assign holds  = 1'b0;
    assign lock_n = 1'b0;
`endif

    // round-robin search from last_grant+1 and next-state selection
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = CORES; i >= 1; i--) begin
            if (elig[(int'(last_grant) + i) % CORES]) begin
                win   = GW'((int'(last_grant) + i) % CORES);
                found = 1'b1;
            end
        end
        state_n = state == IDLE  ? (found ? ISSUE : IDLE) :
                  state == ISSUE ? WAIT :
                  state == WAIT  ? (cnt == CW'(1) ? ACK : WAIT) : IDLE;
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= GW'(CORES - 1);
            cnt           <= '0;
            bus.ack       <= '0;
            bus.rdata     <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.grant_id  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            state      <= state_n;
            bus.mem_en <= state_n == ISSUE;
            bus.busy   <= state_n != IDLE;
            bus.ack    <= state_n == ACK ? gsel : '0;
            if (state == IDLE && found) begin
                bus.grant_id  <= win;
                bus.mem_we    <= bus.we[win];
                bus.mem_addr  <= bus.addr[win*ADDR_W +: ADDR_W];
                bus.mem_wdata <= bus.wdata[win*DATA_W +: DATA_W];
            end
            if (state == ISSUE)
                cnt <= CW'(MEM_LAT);
            if (state == WAIT) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1) && !bus.mem_we)
                    bus.rdata <= bus.mem_rdata;
            end
            if (state == ACK && !lock_n)
                last_grant <= bus.grant_id;
        end
    end
endmodule
